// File: rtl/fft_result_streamer.sv
// FFT output stage: captures indexed butterfly results into a ping-pong frame
// buffer and replays each completed frame in natural order on a valid/ready stream.
module fft_result_streamer #(
    parameter int unsigned IDX_W  = 3,
    parameter int unsigned DATA_W = 50
) (
    input  logic              clk_i,
    input  logic              reset,
    input  logic              res_valid,
    input  logic [IDX_W-1:0]  res_idx,
    input  logic [DATA_W-1:0] res_data,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic [IDX_W-1:0]  m_tidx,
    output logic              m_tlast,
    output logic              frame_done,
    output logic              missing,
    output logic              overflow
);

    localparam int unsigned      N        = 1 << IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = '1;
    localparam logic [IDX_W-1:0] ONE      = IDX_W'(1);

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_e;

    state_e                      state_q, state_d;
    logic [1:0]                  full_q, full_d;
    logic [1:0][N-1:0]           wr_map_q, wr_map_d;
    logic                        wb_q, wb_d;
    logic                        rb_q, rb_d;
    logic [IDX_W-1:0]            rd_cnt_q, rd_cnt_d;
    logic                        tvalid_q, tvalid_d;
    logic [DATA_W-1:0]           tdata_q, tdata_d;
    logic                        tlast_q, tlast_d;
    logic                        frame_done_q, frame_done_d;
    logic                        missing_q, missing_d;
    logic                        overflow_q, overflow_d;
    logic [DATA_W-1:0]           mem_q [2][N];

    logic                        handshake;
    logic                        release_bank;
    logic                        wr_en;
    logic                        load;
    logic                        load_bank;
    logic [IDX_W-1:0]            load_idx;

    // A bank being released this cycle still counts as full for the writer.
    always_comb begin
        handshake    = tvalid_q && m_tready;
        release_bank = (state_q == ST_SEND) && handshake && (rd_cnt_q == LAST_IDX);
        wr_en        = res_valid && !full_q[wb_q] && !(release_bank && (rb_q == wb_q));
    end

    always_comb begin
        state_d      = state_q;
        full_d       = full_q;
        wr_map_d     = wr_map_q;
        wb_d         = wb_q;
        rb_d         = rb_q;
        rd_cnt_d     = rd_cnt_q;
        tvalid_d     = tvalid_q;
        tdata_d      = tdata_q;
        tlast_d      = tlast_q;
        frame_done_d = 1'b0;
        missing_d    = missing_q;
        overflow_d   = overflow_q;
        load         = 1'b0;
        load_bank    = rb_q;
        load_idx     = '0;

        if (wr_en) begin
            wr_map_d[wb_q][res_idx] = 1'b1;
            if (res_idx == LAST_IDX) begin
                full_d[wb_q] = 1'b1;
                wb_d         = ~wb_q;
            end
        end
        if (res_valid && !wr_en) begin
            overflow_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (full_q[rb_q]) begin
                    load     = 1'b1;
                    state_d  = ST_SEND;
                    rd_cnt_d = '0;
                end
            end
            ST_SEND: begin
                if (handshake) begin
                    if (rd_cnt_q == LAST_IDX) begin
                        full_d[rb_q]   = 1'b0;
                        wr_map_d[rb_q] = '0;
                        rb_d           = ~rb_q;
                        frame_done_d   = 1'b1;
                        rd_cnt_d       = '0;
                        // Chain straight into the other bank to avoid a bubble.
                        if (full_q[~rb_q]) begin
                            load      = 1'b1;
                            load_bank = ~rb_q;
                        end else begin
                            state_d  = ST_IDLE;
                            tvalid_d = 1'b0;
                            tlast_d  = 1'b0;
                        end
                    end else begin
                        rd_cnt_d = rd_cnt_q + ONE;
                        load     = 1'b1;
                        load_idx = rd_cnt_q + ONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load) begin
            tvalid_d = 1'b1;
            tlast_d  = (load_idx == LAST_IDX);
            if (wr_map_q[load_bank][load_idx]) begin
                tdata_d = mem_q[load_bank][load_idx];
            end else begin
                tdata_d   = '0;
                missing_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            full_q       <= '0;
            wr_map_q     <= '0;
            wb_q         <= 1'b0;
            rb_q         <= 1'b0;
            rd_cnt_q     <= '0;
            tvalid_q     <= 1'b0;
            tdata_q      <= '0;
            tlast_q      <= 1'b0;
            frame_done_q <= 1'b0;
            missing_q    <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            full_q       <= full_d;
            wr_map_q     <= wr_map_d;
            wb_q         <= wb_d;
            rb_q         <= rb_d;
            rd_cnt_q     <= rd_cnt_d;
            tvalid_q     <= tvalid_d;
            tdata_q      <= tdata_d;
            tlast_q      <= tlast_d;
            frame_done_q <= frame_done_d;
            missing_q    <= missing_d;
            overflow_q   <= overflow_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wb_q][res_idx] <= res_data;
        end
    end

    assign m_tvalid   = tvalid_q;
    assign m_tdata    = tdata_q;
    assign m_tidx     = rd_cnt_q;
    assign m_tlast    = tlast_q;
    assign frame_done = frame_done_q;
    assign missing    = missing_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_fft_result_streamer.sv
// Scoreboard bench for fft_result_streamer: a frame-level model queues expected
// samples as results are written; a monitor pops and compares on each handshake.
module tb_fft_result_streamer;

    localparam int IW = 3;
    localparam int DW = 50;
    localparam int N  = 8;

    logic          clk_i     = 1'b0;
    logic          reset     = 1'b1;
    logic          res_valid = 1'b0;
    logic [IW-1:0] res_idx   = '0;
    logic [DW-1:0] res_data  = '0;
    logic          m_tready  = 1'b0;
    logic          m_tvalid;
    logic [DW-1:0] m_tdata;
    logic [IW-1:0] m_tidx;
    logic          m_tlast;
    logic          frame_done;
    logic          missing;
    logic          overflow;

    always #5 clk_i = ~clk_i;

    fft_result_streamer #(.IDX_W(IW), .DATA_W(DW)) dut (
        .clk_i      (clk_i),
        .reset      (reset),
        .res_valid  (res_valid),
        .res_idx    (res_idx),
        .res_data   (res_data),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tdata    (m_tdata),
        .m_tidx     (m_tidx),
        .m_tlast    (m_tlast),
        .frame_done (frame_done),
        .missing    (missing),
        .overflow   (overflow)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [IW-1:0] idx;
        logic          last;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   hs_count = 0;
    int   ready_mode = 0;   // 0 always ready, 1 never, 2 pattern 1,0,0,1, 3 random
    int   rdy_ph = 0;

    // Reference model: the frame under construction and the number of held frames.
    logic [DW-1:0] cur_data [N];
    logic          cur_wr   [N];
    int            held = 0;
    logic          ovf_exp = 1'b0;
    logic          miss_exp = 1'b0;

    always begin
        @(posedge clk_i);
        #1;
        case (ready_mode)
            0: m_tready = 1'b1;
            1: m_tready = 1'b0;
            2: begin
                m_tready = (rdy_ph == 0) || (rdy_ph == 3);
                rdy_ph   = (rdy_ph + 1) % 4;
            end
            default: m_tready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            cur_data[i] = '0;
            cur_wr[i]   = 1'b0;
        end
    endtask

    task automatic model_write(input logic [IW-1:0] idx, input logic [DW-1:0] d);
        exp_t e;
        if (held >= 2) begin
            ovf_exp = 1'b1;
        end else begin
            cur_data[idx] = d;
            cur_wr[idx]   = 1'b1;
            if (idx == IW'(N - 1)) begin
                for (int i = 0; i < N; i++) begin
                    e.data = cur_wr[i] ? cur_data[i] : '0;
                    if (!cur_wr[i]) miss_exp = 1'b1;
                    e.idx  = IW'(i);
                    e.last = (i == N - 1);
                    sb_q.push_back(e);
                end
                held++;
                model_clear();
            end
        end
    endtask

    task automatic write_res(input logic [IW-1:0] idx, input logic [DW-1:0] d);
        res_valid = 1'b1;
        res_idx   = idx;
        res_data  = d;
        @(posedge clk_i);
        #1;
        res_valid = 1'b0;
        model_write(idx, d);
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return DW'({$urandom(), $urandom()});
    endfunction

    task automatic check_zero_outputs(input string tag);
        check({tag, "_tvalid"}, 64'(m_tvalid), 64'd0);
        check({tag, "_tdata"}, 64'(m_tdata), 64'd0);
        check({tag, "_tidx"}, 64'(m_tidx), 64'd0);
        check({tag, "_tlast"}, 64'(m_tlast), 64'd0);
        check({tag, "_frame_done"}, 64'(frame_done), 64'd0);
        check({tag, "_missing"}, 64'(missing), 64'd0);
        check({tag, "_overflow"}, 64'(overflow), 64'd0);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        sb_q.delete();
        held     = 0;
        ovf_exp  = 1'b0;
        miss_exp = 1'b0;
        model_clear();
        @(posedge clk_i);
        #1;
        reset = 1'b0;
        @(negedge clk_i);
        check_zero_outputs(tag);
    endtask

    task automatic wait_drain(input string tag);
        int t = 0;
        while (sb_q.size() != 0 && t < 400) begin
            @(posedge clk_i);
            #1;
            t++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d samples outstanding, required 0", tag, sb_q.size());
            sb_q.delete();
        end
        repeat (3) @(posedge clk_i);
        #1;
        held = 0;
        check({tag, "_idle"}, 64'(m_tvalid), 64'd0);
        check({tag, "_missing"}, 64'(missing), 64'(miss_exp));
        check({tag, "_overflow"}, 64'(overflow), 64'(ovf_exp));
    endtask

    // Monitor: compare each handshake against the scoreboard, plus stall stability
    // and the frame_done pulse following a tlast handshake.
    logic          prev_stall = 1'b0;
    logic          fd_pend = 1'b0;
    logic [DW-1:0] p_data;
    logic [IW-1:0] p_idx;
    logic          p_last;

    always @(negedge clk_i) begin
        exp_t e;
        if (reset) begin
            prev_stall = 1'b0;
            fd_pend    = 1'b0;
        end else begin
            checks++;
            if (frame_done !== fd_pend) begin
                errors++;
                $display("FAIL frame_done: got %0b expected %0b", frame_done, fd_pend);
            end
            if (prev_stall) begin
                checks++;
                if (m_tvalid !== 1'b1 || m_tdata !== p_data || m_tidx !== p_idx || m_tlast !== p_last) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%0b d=%0d i=%0d l=%0b expected v=1 d=%0d i=%0d l=%0b",
                             m_tvalid, $signed(m_tdata), m_tidx, m_tlast, $signed(p_data), p_idx, p_last);
                end
            end
            fd_pend = 1'b0;
            if (m_tvalid && m_tready) begin
                hs_count++;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sample: got unexpected d=%0d i=%0d, expected no output",
                             $signed(m_tdata), m_tidx);
                end else begin
                    e = sb_q.pop_front();
                    if (m_tdata !== e.data || m_tidx !== e.idx || m_tlast !== e.last) begin
                        errors++;
                        $display("FAIL sample: got d=%0d i=%0d l=%0b expected d=%0d i=%0d l=%0b",
                                 $signed(m_tdata), m_tidx, m_tlast, $signed(e.data), e.idx, e.last);
                    end
                    fd_pend = e.last;
                end
            end
            prev_stall = m_tvalid && !m_tready;
            p_data     = m_tdata;
            p_idx      = m_tidx;
            p_last     = m_tlast;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] bv [N];
        int            ooo [N];
        int            base;
        int            streak;
        int            t;
        int            nf;
        int            nw;

        model_clear();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check_zero_outputs("in_reset");
        @(posedge clk_i);
        #1;
        reset = 1'b0;
        @(negedge clk_i);
        check_zero_outputs("after_reset");

        // Basic frame with boundary values and the 2-cycle valid latency.
        bv[0] = '0;
        bv[1] = DW'(1);
        bv[2] = '1;
        bv[3] = DW'(100);
        bv[4] = DW'(-100);
        bv[5] = {1'b0, {(DW-1){1'b1}}};
        bv[6] = {1'b1, {(DW-1){1'b0}}};
        bv[7] = DW'(7);
        ready_mode = 0;
        @(posedge clk_i);
        #1;
        for (int i = 0; i < N; i++) write_res(IW'(i), bv[i]);
        @(negedge clk_i);
        check("tvalid_one_after", 64'(m_tvalid), 64'd0);
        @(negedge clk_i);
        check("tvalid_two_after", 64'(m_tvalid), 64'd1);
        wait_drain("basic");

        // Out-of-order fill.
        ooo = '{3, 0, 6, 1, 5, 2, 4, 7};
        for (int i = 0; i < N; i++) write_res(IW'(ooo[i]), DW'(10 * ooo[i]));
        wait_drain("ooo");

        // Backpressure pattern during drain.
        ready_mode = 2;
        base = hs_count;
        for (int i = 0; i < N; i++) write_res(IW'(i), rnd_data());
        wait_drain("bp");
        check("bp_handshakes", 64'(hs_count - base), 64'd8);

        // Ping-pong fill with sink stalled, then a third frame that must be dropped.
        @(negedge clk_i);
        ready_mode = 1;
        @(posedge clk_i);
        #1;
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < N; i++) write_res(IW'(i), rnd_data());
        check("overflow_set", 64'(overflow), 64'd1);
        @(negedge clk_i);
        ready_mode = 0;
        @(posedge clk_i);
        #2;
        streak = 0;
        repeat (16) begin
            @(negedge clk_i);
            if (m_tvalid && m_tready) streak++;
        end
        check("b2b_streak", 64'(streak), 64'd16);
        wait_drain("pingpong");

        // Random frames with random sink readiness; duplicates and gaps allowed.
        ready_mode = 3;
        for (int r = 0; r < 8; r++) begin
            nf = $urandom_range(1, 2);
            for (int f = 0; f < nf; f++) begin
                nw = $urandom_range(4, 12);
                for (int k = 0; k < nw; k++) begin
                    write_res(IW'($urandom_range(0, N - 2)), rnd_data());
                    repeat ($urandom_range(0, 2)) @(posedge clk_i);
                    #1;
                end
                write_res(IW'(N - 1), rnd_data());
            end
            wait_drain("random");
        end

        // Missing slots.
        ready_mode = 0;
        do_reset("reset_pre_missing");
        write_res(IW'(0), DW'(5));
        write_res(IW'(7), DW'(9));
        wait_drain("missing");
        check("missing_set", 64'(missing), 64'd1);

        // Reset mid-drain after the third handshake, then a clean frame.
        do_reset("reset_pre_middrain");
        base = hs_count;
        for (int i = 0; i < N; i++) write_res(IW'(i), rnd_data());
        t = 0;
        while (hs_count < base + 3 && t < 50) begin
            @(negedge clk_i);
            #1;
            t++;
        end
        check("third_handshake_seen", 64'(hs_count - base), 64'd3);
        @(posedge clk_i);
        #1;
        do_reset("reset_middrain");
        for (int i = 0; i < N; i++) write_res(IW'(i), rnd_data());
        wait_drain("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_result_streamer.md
# fft_result_streamer

Downstream output stage of the FFT datapath. Captures the per-point results emitted by the butterfly pipeline (data plus point index) into a two-bank (ping-pong) frame buffer. Each completed frame is re-emitted in natural index order on a valid/ready output stream with a frame-end marker. While one frame drains, the next frame can fill the other bank.

## Interface
- IDX_W, default 3: width of the point index. Frame length is N = 2**IDX_W (8 points).
- DATA_W, default 50: width of one signed result sample.
- clk_i  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- res_valid  in  1  strobe: res_idx/res_data carry one result this cycle.
- res_idx  in  IDX_W  point index of the result, 0..N-1.
- res_data  in  DATA_W  signed result sample.
- m_tvalid  out  1  output sample valid.
- m_tready  in  1  downstream ready.
- m_tdata  out  DATA_W  signed output sample.
- m_tidx  out  IDX_W  index of the sample on m_tdata.
- m_tlast  out  1  high with the sample of index N-1.
- frame_done  out  1  one-cycle pulse after the tlast handshake.
- missing  out  1  sticky: a drained frame had unwritten slots.
- overflow  out  1  sticky: a result was dropped because both banks were full.

## Operation
- Storage: mem[2][N] of DATA_W bits, plus per-bank written bitmap wr_map[2] (N bits) and full[2].
- Write side: pointer wb selects the fill bank.
  - On res_valid with full[wb]==0: mem[wb][res_idx] <= res_data; set wr_map[wb][res_idx].
  - Duplicate indices overwrite; the last value wins.
  - res_idx == N-1 closes the frame: full[wb] <= 1 and wb toggles. Write order is otherwise free.
  - On res_valid with full[wb]==1: the result is dropped and overflow <= 1.
- Read side FSM, pointer rb, counter rd_cnt:
  - IDLE: m_tvalid=0. When full[rb]==1, go to SEND and present slot 0.
  - SEND: present mem[rb][rd_cnt]. If wr_map[rb][rd_cnt]==0, output 0 and set missing.
    - m_tidx = rd_cnt; m_tlast = (rd_cnt == N-1).
    - On a handshake (m_tvalid && m_tready), rd_cnt increments.
    - On the handshake with rd_cnt == N-1: clear full[rb] and wr_map[rb], toggle rb, pulse frame_done next cycle, set rd_cnt=0. Then go to SEND if full[next rb]==1, else to IDLE.
- A write and a read-side release of the same bank in the same cycle: the release wins. That bank accepts writes from the next cycle only, and the result that cycle is dropped with overflow set.
- Arithmetic: no data modification. Samples pass through bit-exact, sign preserved.
- Reset (any time, including mid-frame):
  - m_tvalid=0, m_tdata=0, m_tidx=0, m_tlast=0, frame_done=0, missing=0, overflow=0.
  - full, wr_map, wb, rb, rd_cnt cleared; FSM goes to IDLE.
  - mem contents are don't-care.

## Timing
- All outputs are registered.
- m_tvalid rises 2 cycles after the clock edge that accepts the res_idx==N-1 write, when the read side is IDLE: edge k sets full, edge k+1 loads the output register.
- Streaming rate: one sample per cycle while m_tready=1. With m_tready held high, a frame drains in N cycles.
- Back-to-back banks: with the second bank full, the first sample of the next frame appears on the cycle after the tlast handshake. There are no bubbles.
- While m_tvalid=1 and m_tready=0, m_tdata, m_tidx and m_tlast hold stable. m_tvalid never drops without a handshake.
- frame_done is high for exactly one cycle, the cycle after the tlast handshake.
- missing and overflow stay high until reset.

## Test plan
- Basic frame:
  - Stimulus: write idx 0..7 with data 0,1,−1,100,−100,2**49−1,−2**49,7 on consecutive cycles; m_tready=1.
  - Required: m_tvalid rises 2 cycles after the idx 7 write. Eight samples emerge in that order with m_tidx 0..7, m_tlast only on idx 7, frame_done one cycle after, missing=0.
- Out-of-order fill:
  - Stimulus: write idx 3,0,6,1,5,2,4,7 with data = 10*idx.
  - Required: output is 0,10,…,70 in index order.
- Backpressure:
  - Stimulus: m_tready toggles 1,0,0,1 repeatedly during drain.
  - Required: m_tdata/m_tidx stable across stalls, no sample lost or duplicated, 8 handshakes total.
- Ping-pong and overflow:
  - Stimulus: m_tready=0; write three full frames.
  - Required: the first two frames are stored, every result of frame 3 is dropped, overflow=1.
  - Then raise m_tready: frames 1 and 2 emerge back-to-back (16 consecutive handshakes); frame 3 never appears.
- Missing slots:
  - Stimulus: write only idx 0 (data 5) and idx 7 (data 9).
  - Required: output is 5,0,0,0,0,0,0,9 and missing=1.
- Reset mid-drain:
  - Stimulus: assert reset after the 3rd handshake.
  - Required: next cycle all outputs are 0. A following clean frame drains correctly from idx 0.
